mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 60 ++++++
 rtl/mem_lsu.sv | 114 +++++++++++
 tb/tb_mem_lsu.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: bus widths, aluop codes,
// FSM state encodings and small opcode-class helpers.
package mem_lsu_pkg;

  typedef logic [7:0]  alu_op_bus_t;
  typedef logic [31:0] reg_bus_t;
  typedef logic [4:0]  reg_addr_bus_t;
  typedef logic [31:0] data_addr_bus_t;

  localparam reg_addr_bus_t NOP_REG_ADDR = 5'b00000;
  localparam reg_bus_t      ZERO_WORD    = 32'h0000_0000;

  localparam alu_op_bus_t EXE_NOP = 8'b0000_0000;
  localparam alu_op_bus_t EXE_ADD = 8'b0010_0000;
  localparam alu_op_bus_t EXE_LB  = 8'b1110_0000;
  localparam alu_op_bus_t EXE_LH  = 8'b1110_0001;
  localparam alu_op_bus_t EXE_LW  = 8'b1110_0011;
  localparam alu_op_bus_t EXE_LBU = 8'b1110_0100;
  localparam alu_op_bus_t EXE_LHU = 8'b1110_0101;
  localparam alu_op_bus_t EXE_SB  = 8'b1110_1000;
  localparam alu_op_bus_t EXE_SH  = 8'b1110_1001;
  localparam alu_op_bus_t EXE_SW  = 8'b1110_1011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic op_is_load(input alu_op_bus_t op);
    return op inside {EXE_LB, EXE_LH, EXE_LW, EXE_LBU, EXE_LHU};
  endfunction

  function automatic logic op_is_store(input alu_op_bus_t op);
    return op inside {EXE_SB, EXE_SH, EXE_SW};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment datapath: byte enables, lane-replicated store data,
// load byte/halfword selection with sign/zero extension, misalignment detect.
module lsu_align
  import mem_lsu_pkg::*;
(
  input  alu_op_bus_t aluop,
  input  logic [1:0]  offset,
  input  reg_bus_t    reg2,
  input  reg_bus_t    rdata,
  output logic [3:0]  be,
  output reg_bus_t    store_data,
  output reg_bus_t    load_data,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be         = 4'b1111;
    store_data = reg2;
    load_data  = rdata;
    misalign   = 1'b0;
    case (aluop)
      EXE_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      EXE_LBU: load_data = {24'h0, byte_sel};
      EXE_LH: begin
        load_data = {{16{half_sel[15]}}, half_sel};
        misalign  = offset[0];
      end
      EXE_LHU: begin
        load_data = {16'h0, half_sel};
        misalign  = offset[0];
      end
      EXE_LW:  misalign = |offset;
      EXE_SB: begin
        be         = 4'b0001 << offset;
        store_data = {4{reg2[7:0]}};
      end
      EXE_SH: begin
        be         = offset[1] ? 4'b1100 : 4'b0011;
        store_data = {2{reg2[15:0]}};
        misalign   = offset[0];
      end
      EXE_SW:  misalign = |offset;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: stalls the pipeline while one data-bus
// transaction runs through IDLE -> (REQ) -> RESP, then writes back.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  reg_addr_bus_t  mem_wd_i,
  input  logic           mem_wreg_i,
  input  reg_bus_t       mem_wdata_i,
  input  alu_op_bus_t    mem_aluop_i,
  input  data_addr_bus_t mem_addr_i,
  input  reg_bus_t       mem_reg2_i,
  output reg_addr_bus_t  wb_wd_o,
  output logic           wb_wreg_o,
  output reg_bus_t       wb_wdata_o,
  output logic           dbus_req_o,
  output logic           dbus_we_o,
  output data_addr_bus_t dbus_addr_o,
  output logic [3:0]     dbus_be_o,
  output reg_bus_t       dbus_wdata_o,
  input  logic           dbus_gnt_i,
  input  logic           dbus_rvalid_i,
  input  reg_bus_t       dbus_rdata_i,
  output logic           stallreq_o,
  output logic           misalign_o
);

  // Handshake: a request is held (req plus address/be/we/wdata) until the
  // cycle where gnt=1; the response is the single later cycle with rvalid=1.

  logic [1:0] state;
  logic [1:0] state_next;
  logic       is_load;
  logic       is_store;
  logic       misalign;
  logic [3:0] be;
  reg_bus_t   store_data;
  reg_bus_t   load_data;
  logic       req;
  logic       stall;
  logic       misal_pulse;
  logic       wreg;
  logic       bus_active;

  assign is_load  = op_is_load(mem_aluop_i);
  assign is_store = op_is_store(mem_aluop_i);

  lsu_align u_align (
    .aluop      (mem_aluop_i),
    .offset     (mem_addr_i[1:0]),
    .reg2       (mem_reg2_i),
    .rdata      (dbus_rdata_i),
    .be         (be),
    .store_data (store_data),
    .load_data  (load_data),
    .misalign   (misalign)
  );

  // Once a transaction has left IDLE it completes regardless of the opcode.
  always_comb begin
    state_next  = state;
    req         = 1'b0;
    stall       = 1'b0;
    misal_pulse = 1'b0;
    wreg        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!(is_load || is_store)) begin
          wreg = mem_wreg_i;
        end else if (misalign) begin
          misal_pulse = 1'b1;
        end else begin
          req        = 1'b1;
          stall      = 1'b1;
          state_next = dbus_gnt_i ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        req   = 1'b1;
        stall = 1'b1;
        if (dbus_gnt_i) state_next = ST_RESP;
      end
      ST_RESP: begin
        if (dbus_rvalid_i) begin
          state_next = ST_IDLE;
          wreg       = is_load & mem_wreg_i;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Outputs are forced to zero while reset is held.
  assign bus_active   = rst & req;
  assign wb_wd_o      = rst ? mem_wd_i : NOP_REG_ADDR;
  assign wb_wreg_o    = rst & wreg;
  assign wb_wdata_o   = !rst ? ZERO_WORD : (is_load ? load_data : mem_wdata_i);
  assign dbus_req_o   = bus_active;
  assign dbus_we_o    = bus_active & is_store;
  assign dbus_addr_o  = bus_active ? {mem_addr_i[31:2], 2'b00} : 32'h0;
  assign dbus_be_o    = bus_active ? be : 4'b0000;
  assign dbus_wdata_o = (bus_active && is_store) ? store_data : ZERO_WORD;
  assign stallreq_o   = rst & stall;
  assign misalign_o   = rst & misal_pulse;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: passthrough, loads/stores with varied grant
// timing, misalignment and reset during a response.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i;
  logic [31:0] mem_wdata_i;
  logic [7:0]  mem_aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_reg2_i;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o;
  logic [31:0] wb_wdata_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_gnt_i;
  logic        dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;
  logic        stallreq_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;
  int stall_cnt;
  logic [31:0] exp_q[$];

  mem_lsu dut (
    .clk           (clk),
    .rst           (rst),
    .mem_wd_i      (mem_wd_i),
    .mem_wreg_i    (mem_wreg_i),
    .mem_wdata_i   (mem_wdata_i),
    .mem_aluop_i   (mem_aluop_i),
    .mem_addr_i    (mem_addr_i),
    .mem_reg2_i    (mem_reg2_i),
    .wb_wd_o       (wb_wd_o),
    .wb_wreg_o     (wb_wreg_o),
    .wb_wdata_o    (wb_wdata_o),
    .dbus_req_o    (dbus_req_o),
    .dbus_we_o     (dbus_we_o),
    .dbus_addr_o   (dbus_addr_o),
    .dbus_be_o     (dbus_be_o),
    .dbus_wdata_o  (dbus_wdata_o),
    .dbus_gnt_i    (dbus_gnt_i),
    .dbus_rvalid_i (dbus_rvalid_i),
    .dbus_rdata_i  (dbus_rdata_i),
    .stallreq_o    (stallreq_o),
    .misalign_o    (misalign_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_op(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata, input logic [31:0] addr,
                        input logic [31:0] reg2);
    mem_aluop_i = op;
    mem_wd_i    = wd;
    mem_wreg_i  = wreg;
    mem_wdata_i = wdata;
    mem_addr_i  = addr;
    mem_reg2_i  = reg2;
  endtask

  task automatic set_bus(input logic gnt, input logic rvalid, input logic [31:0] rdata);
    dbus_gnt_i    = gnt;
    dbus_rvalid_i = rvalid;
    dbus_rdata_i  = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wd"},     32'(wb_wd_o), 32'h0);
    check({tag, "_wreg"},   32'(wb_wreg_o), 32'h0);
    check({tag, "_wdata"},  wb_wdata_o, 32'h0);
    check({tag, "_req"},    32'(dbus_req_o), 32'h0);
    check({tag, "_we"},     32'(dbus_we_o), 32'h0);
    check({tag, "_addr"},   dbus_addr_o, 32'h0);
    check({tag, "_be"},     32'(dbus_be_o), 32'h0);
    check({tag, "_bwdata"}, dbus_wdata_o, 32'h0);
    check({tag, "_stall"},  32'(stallreq_o), 32'h0);
    check({tag, "_misal"},  32'(misalign_o), 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    set_op(EXE_ADD, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0);
    set_bus(1'b0, 1'b0, 32'h0);
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // ALU passthrough
    next_cycle();
    set_op(EXE_ADD, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0);
    #1;
    check("add_wd",    32'(wb_wd_o), 32'd5);
    check("add_wreg",  32'(wb_wreg_o), 32'd1);
    check("add_wdata", wb_wdata_o, 32'h1234);
    check("add_req",   32'(dbus_req_o), 32'd0);
    check("add_stall", 32'(stallreq_o), 32'd0);

    // LB at 0x103, grant on the third request cycle, stray rvalid while in REQ
    stall_cnt = 0;
    next_cycle();
    set_op(EXE_LB, 5'd7, 1'b1, 32'hDEAD, 32'h103, 32'h0);
    set_bus(1'b0, 1'b0, 32'h0);
    exp_q.push_back(32'hFFFF_FF80);
    #1;
    if (stallreq_o) stall_cnt++;
    check("lb_req1",  32'(dbus_req_o), 32'd1);
    check("lb_addr",  dbus_addr_o, 32'h100);
    check("lb_be",    32'(dbus_be_o), 32'hF);
    check("lb_we",    32'(dbus_we_o), 32'd0);
    check("lb_wreg1", 32'(wb_wreg_o), 32'd0);
    next_cycle();
    set_bus(1'b0, 1'b1, 32'h5555_5555);
    #1;
    if (stallreq_o) stall_cnt++;
    check("lb_req2",   32'(dbus_req_o), 32'd1);
    check("lb_addr2",  dbus_addr_o, 32'h100);
    check("lb_wreg2",  32'(wb_wreg_o), 32'd0);
    next_cycle();
    set_bus(1'b1, 1'b0, 32'h0);
    #1;
    if (stallreq_o) stall_cnt++;
    check("lb_req3", 32'(dbus_req_o), 32'd1);
    next_cycle();
    set_bus(1'b0, 1'b1, 32'h80FF_FFFF);
    #1;
    if (stallreq_o) stall_cnt++;
    check("lb_req4",    32'(dbus_req_o), 32'd0);
    check("lb_wreg",    32'(wb_wreg_o), 32'd1);
    check("lb_wd",      32'(wb_wd_o), 32'd7);
    check("lb_wdata",   wb_wdata_o, exp_q.pop_front());
    check("lb_stall_n", 32'(stall_cnt), 32'd3);

    // SH at 0x202, granted immediately
    next_cycle();
    set_op(EXE_SH, 5'd4, 1'b1, 32'h0, 32'h202, 32'hABCD_1234);
    set_bus(1'b1, 1'b0, 32'h0);
    #1;
    check("sh_req",    32'(dbus_req_o), 32'd1);
    check("sh_we",     32'(dbus_we_o), 32'd1);
    check("sh_addr",   dbus_addr_o, 32'h200);
    check("sh_be",     32'(dbus_be_o), 32'hC);
    check("sh_bwdata", dbus_wdata_o, 32'h1234_1234);
    check("sh_stall",  32'(stallreq_o), 32'd1);
    check("sh_wreg1",  32'(wb_wreg_o), 32'd0);
    next_cycle();
    set_bus(1'b0, 1'b1, 32'h0);
    #1;
    check("sh_stall2", 32'(stallreq_o), 32'd0);
    check("sh_wreg2",  32'(wb_wreg_o), 32'd0);
    check("sh_req2",   32'(dbus_req_o), 32'd0);

    // SB at 0x301, granted immediately
    next_cycle();
    set_op(EXE_SB, 5'd4, 1'b0, 32'h0, 32'h301, 32'h0000_0055);
    set_bus(1'b1, 1'b0, 32'h0);
    #1;
    check("sb_be",     32'(dbus_be_o), 32'h2);
    check("sb_bwdata", dbus_wdata_o, 32'h5555_5555);
    next_cycle();
    set_bus(1'b0, 1'b1, 32'h0);
    #1;
    check("sb_stall", 32'(stallreq_o), 32'd0);

    // Misaligned LW at 0x101
    next_cycle();
    set_op(EXE_LW, 5'd6, 1'b1, 32'h0, 32'h101, 32'h0);
    set_bus(1'b1, 1'b0, 32'h0);
    #1;
    check("lw_mis_pulse", 32'(misalign_o), 32'd1);
    check("lw_mis_req",   32'(dbus_req_o), 32'd0);
    check("lw_mis_stall", 32'(stallreq_o), 32'd0);
    check("lw_mis_wreg",  32'(wb_wreg_o), 32'd0);
    next_cycle();
    set_op(EXE_ADD, 5'd2, 1'b1, 32'h77, 32'h0, 32'h0);
    set_bus(1'b0, 1'b0, 32'h0);
    #1;
    check("lw_mis_clear", 32'(misalign_o), 32'd0);
    check("lw_mis_idle",  32'(wb_wreg_o), 32'd1);

    // LHU at 0x2, granted immediately
    next_cycle();
    set_op(EXE_LHU, 5'd9, 1'b1, 32'h0, 32'h2, 32'h0);
    set_bus(1'b1, 1'b0, 32'h0);
    exp_q.push_back(32'h0000_BEEF);
    #1;
    check("lhu_req",   32'(dbus_req_o), 32'd1);
    check("lhu_stall", 32'(stallreq_o), 32'd1);
    next_cycle();
    set_bus(1'b0, 1'b1, 32'hBEEF_0000);
    #1;
    check("lhu_wdata", wb_wdata_o, exp_q.pop_front());
    check("lhu_wreg",  32'(wb_wreg_o), 32'd1);
    check("lhu_stall2", 32'(stallreq_o), 32'd0);

    // LH at 0x0 with negative halfword
    next_cycle();
    set_op(EXE_LH, 5'd10, 1'b1, 32'h0, 32'h0, 32'h0);
    set_bus(1'b1, 1'b0, 32'h0);
    exp_q.push_back(32'hFFFF_8001);
    next_cycle();
    set_bus(1'b0, 1'b1, 32'h1234_8001);
    #1;
    check("lh_wdata", wb_wdata_o, exp_q.pop_front());

    // Reset while in RESP, then stale rvalid must not complete anything
    next_cycle();
    set_op(EXE_LW, 5'd3, 1'b1, 32'h0, 32'h400, 32'h0);
    set_bus(1'b1, 1'b0, 32'h0);
    #1;
    check("rst_lw_req", 32'(dbus_req_o), 32'd1);
    next_cycle();
    set_bus(1'b0, 1'b0, 32'h0);
    #1;
    check("rst_lw_resp_stall", 32'(stallreq_o), 32'd1);
    rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    rst = 1'b1;
    set_bus(1'b0, 1'b1, 32'hCAFE_F00D);
    #1;
    check("post_rst_wreg",  32'(wb_wreg_o), 32'd0);
    check("post_rst_stall", 32'(stallreq_o), 32'd1);
    check("post_rst_req",   32'(dbus_req_o), 32'd1);
    next_cycle();
    set_bus(1'b1, 1'b0, 32'h0);
    exp_q.push_back(32'h1122_3344);
    #1;
    check("post_rst_req2", 32'(dbus_req_o), 32'd1);
    next_cycle();
    set_bus(1'b0, 1'b1, 32'h1122_3344);
    #1;
    check("post_rst_wdata", wb_wdata_o, exp_q.pop_front());
    check("post_rst_wreg2", 32'(wb_wreg_o), 32'd1);
    next_cycle();
    set_op(EXE_NOP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    set_bus(1'b0, 1'b0, 32'h0);
    #1;
    check("final_idle_req", 32'(dbus_req_o), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
